// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM style bus between the timer controller (master) and the timer slave.
interface timer_ctrl_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Timer controller bus master: programs the timer slave, services each interrupt by
// latching a {hi,lo} counter snapshot, and watches the interrupt wait with a watchdog.
module timer_ctrl_master #(
  parameter logic [31:0] IRQ_TIMEOUT = 32'd100_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [31:0]                period_in,
  input  logic                       continuous,
  input  logic                       irq,
  timer_ctrl_master_if.master        bus,
  output logic                       busy,
  output logic                       tick,
  output logic [15:0]                tick_count,
  output logic [31:0]                snapshot,
  output logic                       error
);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PER_L  = 3'd2;
  localparam logic [2:0] ADDR_PER_H  = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H = 3'd5;

  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_WAIT_IRQ,
    ST_CLR_STAT,
    ST_WR_SNAP,
    ST_RD_SL,
    ST_CAP_L,
    ST_RD_SH,
    ST_CAP_H,
    ST_WR_STOP,
    ST_CLR_FIN
  } state_t;

  state_t      state_q;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pending_q;
  logic [31:0] wdog_q;
  logic [15:0] snap_lo_q;
  logic [31:0] snapshot_q;
  logic [15:0] tick_count_q;
  logic        tick_q;
  logic        error_q;
  logic        busy_q;
  logic        cs_q;
  logic        write_n_q;
  logic [2:0]  address_q;
  logic [15:0] writedata_q;

  logic wdog_expired;
  assign wdog_expired = (IRQ_TIMEOUT != 32'd0) && ((wdog_q + 32'd1) == IRQ_TIMEOUT);

  // Bus registers hold the access of the state being entered, so every access
  // lines up with its state and start-to-first-write is one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      period_q       <= '0;
      cont_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      wdog_q         <= '0;
      snap_lo_q      <= '0;
      snapshot_q     <= '0;
      tick_count_q   <= '0;
      tick_q         <= 1'b0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
      cs_q           <= 1'b0;
      write_n_q      <= 1'b1;
      address_q      <= '0;
      writedata_q    <= '0;
    end else begin
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      address_q   <= '0;
      writedata_q <= '0;
      tick_q      <= 1'b0;
      if (stop && busy_q) stop_pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            period_q     <= period_in;
            cont_q       <= continuous;
            tick_count_q <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_WR_PL;
            cs_q         <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= ADDR_PER_L;
            writedata_q  <= period_in[15:0];
          end
        end
        ST_WR_PL: begin
          state_q     <= ST_WR_PH;
          cs_q        <= 1'b1;
          write_n_q   <= 1'b0;
          address_q   <= ADDR_PER_H;
          writedata_q <= period_q[31:16];
        end
        ST_WR_PH: begin
          state_q     <= ST_WR_CTRL;
          cs_q        <= 1'b1;
          write_n_q   <= 1'b0;
          address_q   <= ADDR_CTRL;
          writedata_q <= {13'b0, 1'b1, cont_q, 1'b1};
        end
        ST_WR_CTRL: begin
          state_q <= ST_WAIT_IRQ;
          wdog_q  <= '0;
        end
        ST_WAIT_IRQ: begin
          if (irq) begin
            state_q     <= ST_CLR_STAT;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            address_q   <= ADDR_STATUS;
            writedata_q <= 16'h0000;
          end else if (stop_pending_q || wdog_expired) begin
            if (!stop_pending_q) error_q <= 1'b1;
            state_q     <= ST_WR_STOP;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            address_q   <= ADDR_CTRL;
            writedata_q <= CTRL_STOP;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        ST_CLR_STAT: begin
          state_q     <= ST_WR_SNAP;
          cs_q        <= 1'b1;
          write_n_q   <= 1'b0;
          address_q   <= ADDR_SNAP_L;
          writedata_q <= 16'h0000;
        end
        ST_WR_SNAP: begin
          state_q   <= ST_RD_SL;
          cs_q      <= 1'b1;
          address_q <= ADDR_SNAP_L;
        end
        ST_RD_SL: begin
          state_q   <= ST_CAP_L;
          cs_q      <= 1'b1;
          address_q <= ADDR_SNAP_H;
        end
        ST_CAP_L: begin
          snap_lo_q <= bus.readdata;
          state_q   <= ST_CAP_H;
          tick_q    <= 1'b1;
        end
        ST_RD_SH: begin
          state_q <= ST_CAP_H;
        end
        ST_CAP_H: begin
          // Both halves land together so snapshot never shows a torn value.
          snapshot_q   <= {bus.readdata, snap_lo_q};
          tick_count_q <= tick_count_q + 16'd1;
          if (stop_pending_q) begin
            state_q     <= ST_WR_STOP;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            address_q   <= ADDR_CTRL;
            writedata_q <= CTRL_STOP;
          end else if (cont_q) begin
            state_q <= ST_WAIT_IRQ;
            wdog_q  <= '0;
          end else begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            stop_pending_q <= 1'b0;
          end
        end
        ST_WR_STOP: begin
          state_q     <= ST_CLR_FIN;
          cs_q        <= 1'b1;
          write_n_q   <= 1'b0;
          address_q   <= ADDR_STATUS;
          writedata_q <= 16'h0000;
        end
        ST_CLR_FIN: begin
          state_q        <= ST_IDLE;
          busy_q         <= 1'b0;
          stop_pending_q <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          busy_q         <= 1'b0;
          stop_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.chipselect = cs_q;
  assign bus.write_n    = write_n_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign busy           = busy_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign snapshot       = snapshot_q;
  assign error          = error_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master: stimulus queues expected bus accesses,
// a negedge monitor pops and compares each access the DUT presents.
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period_in = '0;
  logic        continuous = 1'b0;
  logic        irq = 1'b0;
  logic        busy;
  logic        tick;
  logic [15:0] tick_count;
  logic [31:0] snapshot;
  logic        error;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.IRQ_TIMEOUT(32'd16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .period_in  (period_in),
    .continuous (continuous),
    .irq        (irq),
    .bus        (bus.master),
    .busy       (busy),
    .tick       (tick),
    .tick_count (tick_count),
    .snapshot   (snapshot),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } xact_t;

  xact_t exp_q[$];
  xact_t mon_e;
  int    total = 0;
  int    bad = 0;
  int    cyc_cnt = 0;
  int    ticks_seen = 0;
  bit    mon_en = 1'b0;
  logic [31:0] slave_snap = '0;
  logic [15:0] rd_pend = '0;

  always @(posedge clk) cyc_cnt++;

  // Slave read data: valid exactly one cycle after the read address.
  always @(negedge clk) begin
    rd_pend = 16'h0000;
    if (bus.chipselect === 1'b1 && bus.write_n === 1'b1) begin
      if (bus.address == 3'd4) rd_pend = slave_snap[15:0];
      else if (bus.address == 3'd5) rd_pend = slave_snap[31:16];
    end
  end
  always @(posedge clk) begin
    #1;
    bus.readdata = rd_pend;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (bus.chipselect === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%h at cyc %0d, wanted no access",
                   !bus.write_n, bus.address, bus.writedata, cyc_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.write_n !== !mon_e.wr || bus.address !== mon_e.addr ||
              (mon_e.wr && bus.writedata !== mon_e.data) ||
              (mon_e.cyc >= 0 && mon_e.cyc != cyc_cnt)) begin
            bad++;
            $display("FAIL bus_access: got wr=%0b addr=%0d data=%h cyc=%0d, wanted wr=%0b addr=%0d data=%h cyc=%0d",
                     !bus.write_n, bus.address, bus.writedata, cyc_cnt,
                     mon_e.wr, mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
      end else if (bus.chipselect !== 1'b0 || bus.write_n !== 1'b1 ||
                   bus.address !== 3'd0 || bus.writedata !== 16'h0000) begin
        bad++;
        $display("FAIL bus_idle: got cs=%b wn=%b addr=%h data=%h, wanted cs=0 wn=1 addr=0 data=0",
                 bus.chipselect, bus.write_n, bus.address, bus.writedata);
      end
      if (tick === 1'b1) ticks_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [2:0] addr, input logic [15:0] data, input int cyc);
    xact_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_service();
    push(1'b1, 3'd0, 16'h0000, -1);
    push(1'b1, 3'd4, 16'h0000, -1);
    push(1'b0, 3'd4, 16'h0000, -1);
    push(1'b0, 3'd5, 16'h0000, -1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse; t0 is the cycle in which start is high, programming writes follow at t0+1..t0+3.
  task automatic do_start(input logic [31:0] per, input logic cont, output int t0);
    @(posedge clk); #1;
    t0 = cyc_cnt;
    push(1'b1, 3'd2, per[15:0], t0 + 1);
    push(1'b1, 3'd3, per[31:16], t0 + 2);
    push(1'b1, 3'd1, cont ? 16'h0007 : 16'h0005, t0 + 3);
    period_in = per; continuous = cont; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_irq();
    @(posedge clk); #1 irq = 1'b1;
    @(posedge clk); #1 irq = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (tick === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    check(name, 32'(idle), 32'd1);
  endtask

  initial begin
    int t0;
    bit found;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_snapshot", snapshot, 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // Continuous, three interrupts, then stop.
    slave_snap = 32'h0000_1234;
    ticks_seen = 0;
    do_start(32'h0001_86A0, 1'b1, t0);
    wait_cycles(4);
    for (int i = 0; i < 3; i++) begin
      push_service();
      pulse_irq();
      wait_tick("cont_tick_seen");
      wait_cycles(2);
    end
    push(1'b1, 3'd1, 16'h0008, -1);
    push(1'b1, 3'd0, 16'h0000, -1);
    pulse_stop();
    wait_idle("cont_stop_idle");
    check("cont_ticks", 32'(ticks_seen), 32'd3);
    check("cont_tick_count", 32'(tick_count), 32'd3);
    check("cont_snapshot", snapshot, 32'h0000_1234);
    check("cont_error", 32'(error), 32'd0);

    // Stop in IDLE is ignored; one-shot with zero period.
    pulse_stop();
    wait_cycles(2);
    slave_snap = 32'hDEAD_BEEF;
    ticks_seen = 0;
    do_start(32'h0000_0000, 1'b0, t0);
    wait_cycles(4);
    push_service();
    pulse_irq();
    wait_tick("oneshot_tick_seen");
    @(negedge clk);
    check("oneshot_busy_after_caph", 32'(busy), 32'd0);
    check("oneshot_tick_count", 32'(tick_count), 32'd1);
    check("oneshot_snapshot", snapshot, 32'hDEAD_BEEF);
    wait_cycles(3);
    check("oneshot_no_stop_write", 32'(exp_q.size()), 32'd0);

    // Stop and irq in the same WAIT_IRQ cycle: service first, then stop.
    slave_snap = 32'h0BAD_F00D;
    ticks_seen = 0;
    do_start(32'h1234_5678, 1'b1, t0);
    wait_cycles(4);
    push_service();
    push(1'b1, 3'd1, 16'h0008, -1);
    push(1'b1, 3'd0, 16'h0000, -1);
    @(posedge clk); #1 irq = 1'b1; stop = 1'b1;
    @(posedge clk); #1 irq = 1'b0; stop = 1'b0;
    wait_tick("stopirq_tick_seen");
    wait_idle("stopirq_idle");
    check("stopirq_tick_count", 32'(tick_count), 32'd1);
    check("stopirq_snapshot", snapshot, 32'h0BAD_F00D);

    // Watchdog: 16 WAIT_IRQ cycles without irq.
    do_start(32'h0000_0010, 1'b0, t0);
    push(1'b1, 3'd1, 16'h0008, t0 + 20);
    push(1'b1, 3'd0, 16'h0000, t0 + 21);
    wait_idle("wdog_idle");
    check("wdog_error", 32'(error), 32'd1);
    check("wdog_tick_count", 32'(tick_count), 32'd0);

    // Next start clears error; stop during programming is taken at WAIT_IRQ.
    do_start(32'hFFFF_FFFF, 1'b1, t0);
    push(1'b1, 3'd1, 16'h0008, t0 + 5);
    push(1'b1, 3'd0, 16'h0000, t0 + 6);
    @(negedge clk);
    check("restart_error_clr", 32'(error), 32'd0);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle("stopprog_idle");
    check("stopprog_error", 32'(error), 32'd0);

    // Reset during RD_SL of a second service.
    slave_snap = 32'h5555_AAAA;
    do_start(32'h0000_0100, 1'b1, t0);
    wait_cycles(4);
    push_service();
    pulse_irq();
    wait_tick("rst_pre_tick_seen");
    wait_cycles(2);
    check("rst_pre_tick_count", 32'(tick_count), 32'd1);
    push_service();
    pulse_irq();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.chipselect === 1'b1 && bus.write_n === 1'b1 && bus.address === 3'd4) found = 1'b1;
    end
    check("rst_rdsl_found", 32'(found), 32'd1);
    #1;
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_cs", 32'(bus.chipselect), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tick", 32'(tick), 32'd0);
    check("rstmid_tick_count", 32'(tick_count), 32'd0);
    check("rstmid_snapshot", snapshot, 32'd0);
    check("rstmid_error", 32'(error), 32'd0);
    wait_cycles(4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, wanted finish");
    $fatal(1, "timeout");
  end

endmodule
